nlms_weight_update: RTL

- Downstream stage of the 32-tap adaptive filter core. Consumes the error sample `e` and the same tap-buffer snapshot the filter used.
- Serially updates the filter weight bank, one tap per clock: w[k] <= sat(w[k] + ((e * x[k]) >>> MU_SHIFT)).
- Holds all N_TAPS weights in registers and drives them back to the filter's weight inputs.
- Provides a preload port for initial coefficients.

---
 rtl/nlms_weight_update.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/nlms_weight_update.sv
// -----------------------------------------------------------------------------
// nlms_weight_update
//
// Serial NLMS weight-bank updater for the 32-tap adaptive filter core.
// On a start pulse the error sample and the tap snapshot are latched, then one
// tap per clock is updated as
//   w[k] <= sat(w[k] + ((e * x[k]) >>> MU_SHIFT))
// The weights live in registers here and are driven back to the filter.
//
// Ports:
//   clk          rising-edge clock
//   rstn         synchronous active-low reset
//   start        one-cycle pulse, e/x_flat valid, begin an update pass
//   e            signed error sample
//   x_flat       N_TAPS unsigned tap samples, x[k] = x_flat[k*X_WIDTH +: X_WIDTH]
//   clear        zero all weights and abort any pass
//   init_we      preload strobe (IDLE only)
//   init_addr    preload tap index
//   init_data    preload value
//   busy         high from the start-accept edge until back in IDLE
//   done         one-cycle pulse at the end of a pass
//   weight_flat  registered weights, w[k] = weight_flat[k*W_WIDTH +: W_WIDTH]
// -----------------------------------------------------------------------------
module nlms_weight_update #(
  parameter int N_TAPS   = 32,
  parameter int X_WIDTH  = 14,
  parameter int E_WIDTH  = 14,
  parameter int W_WIDTH  = 32,
  parameter int MU_SHIFT = 8
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               start,
  input  logic signed [E_WIDTH-1:0]          e,
  input  logic        [N_TAPS*X_WIDTH-1:0]   x_flat,
  input  logic                               clear,
  input  logic                               init_we,
  input  logic        [4:0]                  init_addr,
  input  logic signed [W_WIDTH-1:0]          init_data,
  output logic                               busy,
  output logic                               done,
  output logic        [N_TAPS*W_WIDTH-1:0]   weight_flat
);

  localparam int CNT_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam int P_W   = E_WIDTH + X_WIDTH + 1;
  localparam int SUM_W = ((P_W > W_WIDTH) ? P_W : W_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(N_TAPS - 1);

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt;
  logic             busy_d, done_d;
  logic             accept, init_ok;

  logic signed [E_WIDTH-1:0] e_p0;
  logic        [X_WIDTH-1:0] x_p0 [N_TAPS];
  logic signed [W_WIDTH-1:0] w    [N_TAPS];

  logic        [X_WIDTH-1:0] x_cur;
  logic signed [P_W-1:0]     prod;
  logic signed [P_W-1:0]     step;
  logic signed [SUM_W-1:0]   sum;
  logic signed [W_WIDTH-1:0] w_next;

  // Clamp a wide sum into the weight range instead of letting it wrap.
  function automatic logic signed [W_WIDTH-1:0] sat_w(input logic signed [SUM_W-1:0] v);
    logic signed [SUM_W-1:0] hi, lo;
    hi = '0;
    hi[W_WIDTH-2:0] = '1;
    lo = ~hi;
    if (v > hi)      return hi[W_WIDTH-1:0];
    else if (v < lo) return lo[W_WIDTH-1:0];
    else             return v[W_WIDTH-1:0];
  endfunction

  // Start loses to clear; preload loses to both and only acts when idle.
  assign accept  = (state == IDLE) && start && !clear;
  assign init_ok = (state == IDLE) && init_we && !start && !clear &&
                   (int'(init_addr) < N_TAPS);

  // FSM state register, tap counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= busy_d;
      done  <= done_d;
      cnt   <= (state == UPDATE && state_d == UPDATE) ? cnt + CNT_W'(1) : '0;
    end
  end

  always_comb begin
    state_d = state;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_d = UPDATE;
        UPDATE:  if (cnt == LAST_TAP) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Status is derived from the next state so busy/done come straight from flops.
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Update stage: operands from the p0 latch, one tap selected by the counter.
  // x is zero-extended so the product stays signed at full precision.
  assign x_cur  = x_p0[cnt];
  assign prod   = P_W'(e_p0) * P_W'($signed({1'b0, x_cur}));
  assign step   = prod >>> MU_SHIFT;
  assign sum    = SUM_W'(step) + SUM_W'(w[cnt]);
  assign w_next = sat_w(sum);

  // Stage p0: operand latch at start-accept; weight bank writes.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      e_p0 <= '0;
      for (int k = 0; k < N_TAPS; k++) begin
        x_p0[k] <= '0;
        w[k]    <= '0;
      end
    end else if (clear) begin
      for (int k = 0; k < N_TAPS; k++) w[k] <= '0;
    end else if (accept) begin
      e_p0 <= e;
      for (int k = 0; k < N_TAPS; k++) x_p0[k] <= x_flat[k*X_WIDTH +: X_WIDTH];
    end else if (init_ok) begin
      w[init_addr] <= init_data;
    end else if (state == UPDATE) begin
      w[cnt] <= w_next;
    end
  end

  for (genvar g = 0; g < N_TAPS; g++) begin : g_wout
    assign weight_flat[g*W_WIDTH +: W_WIDTH] = w[g];
  end

endmodule
